rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin controller that shares one WIDTH-bit output channel among four requesters.
- Drives the select of a 4:1 byte datapath mux and holds each grant for a whole burst.
- Uses valid/ready handshakes on both sides.
- Sits between four producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 8: data width of every input and of the output.
- MAX_BURST, 16: maximum beats per grant before forced release (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  req[i] = requester i has a valid beat (acts as valid).
- last  input  4  last[i] = current beat of requester i ends its burst.
- d0  input  WIDTH  requester 0 data.
- d1  input  WIDTH  requester 1 data.
- d2  input  WIDTH  requester 2 data.
- d3  input  WIDTH  requester 3 data.
- rdy  output  4  rdy[i] = beat from requester i accepted this cycle.
- out_ready  input  1  downstream can accept a beat.
- out_valid  output  1  beat present on y.
- y  output  WIDTH  selected data; 0 when out_valid=0.
- out_last  output  1  beat on y is the final beat of its grant.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  registered mux select (index of the granted requester).
- busy  output  1  arbiter is in GRANT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, gnt=0, sel=0, round-robin pointer ptr=0, beat counter cnt=0.
  - out_valid=0, y=0, out_last=0, rdy=0, busy=0.
- States:
  - IDLE: no grant. If req!=0, choose the first set req[i] searching i = ptr, ptr+1, ... mod 4. Next cycle gnt=onehot(i), sel=i, cnt=0, state=GRANT. If req=0, stay in IDLE.
  - GRANT: combinational outputs follow the granted requester:
    - out_valid = req[sel]
    - y = d[sel] when out_valid, else 0
    - rdy[sel] = req[sel] & out_ready; all other rdy bits are 0
    - out_last = out_valid & (last[sel] | cnt==MAX_BURST-1)
- Beat transfer: out_valid & out_ready in GRANT. Each transfer increments cnt (8-bit, never wraps because of forced release).
- Release: occurs on a transfer with out_last=1, or in a GRANT cycle with req[sel]=0 (abort). On release:
  - next cycle state=IDLE, gnt=0, cnt=0.
  - ptr = (sel+1) mod 4.
  - sel keeps its last value.
- Dead cycle: there is always exactly one IDLE cycle between grants. Worst-case grant latency from req rising in IDLE is 1 cycle.
- Stall: out_ready=0 with req[sel]=1 holds the grant indefinitely. y stays stable, and cnt and sel are unchanged.
- Ignored requests: requests from non-granted requesters in GRANT are ignored; they receive rdy=0.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,...
- Simultaneous events: last and the MAX_BURST limit on the same beat cause a single release. Abort takes effect the same cycle req drops; no beat is transferred that cycle.
- Reset mid-burst: immediate return to the reset values. The in-flight beat is not transferred.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 and out_ready=1 → gnt=0, out_valid=0, y=0. After release, gnt=4'b0001 one cycle later.
- Burst: req[2]=1, d2=8'hA5, last[2] asserted on the 3rd beat, out_ready=1 → three beats of A5 on y with sel=2, out_last on beat 3. gnt=0 the following cycle, and the next grant searches from requester 3.
- Round-robin: req=4'b1111 continuously, last=4'b1111 (single-beat bursts) → gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- Forced release: MAX_BURST=4, req[1] held high, last=0 → exactly 4 transfers with out_last on the 4th. Requester 1 then loses the grant and is re-granted only after the IDLE cycle, and only if no higher-priority requester is pending per ptr=2.
- Stall/abort: granted requester 0, out_ready=0 for 5 cycles → y, sel, and cnt stable and rdy=0. Then drop req[0] → release with no transfer, and ptr=1.
- Reset mid-burst: assert rst_n=0 after 2 beats of a 5-beat burst → all outputs return to reset values within the same cycle. After reset, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that shares one output channel among four valid/ready
// requesters. Each grant is held for a whole burst, up to MAX_BURST beats.
module rr_mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       rdy,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             out_last,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic [1:0] ptr_q;
    logic [7:0] cnt_q;

    logic [WIDTH-1:0] d_arr [4];
    logic [1:0]       cand_idx [4];
    logic [3:0]       rot_req;
    logic [1:0]       pick_idx;
    logic             cur_req;
    logic             at_limit;
    logic             xfer;
    logic             release_now;

    assign d_arr[0] = d0;
    assign d_arr[1] = d1;
    assign d_arr[2] = d2;
    assign d_arr[3] = d3;

    // Requests rotated so that position 0 is the highest-priority requester.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign cand_idx[gi] = ptr_q + 2'(gi);
            assign rot_req[gi]  = req[cand_idx[gi]];
            assign rdy[gi]      = xfer & (sel_q == 2'(gi));
        end
    endgenerate

    always_comb begin
        pick_idx = cand_idx[0];
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    assign busy        = (state_q == GRANT);
    assign cur_req     = req[sel_q];
    assign out_valid   = busy & cur_req;
    assign y           = out_valid ? d_arr[sel_q] : '0;
    assign at_limit    = (cnt_q == 8'(MAX_BURST - 1));
    assign out_last    = out_valid & (last[sel_q] | at_limit);
    assign xfer        = out_valid & out_ready;
    // A dropped request aborts the grant without transferring a beat.
    assign release_now = busy & (~cur_req | (xfer & out_last));

    assign gnt = gnt_q;
    assign sel = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= GRANT;
                        gnt_q   <= 4'b0001 << pick_idx;
                        sel_q   <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        ptr_q   <= sel_q + 2'd1;
                    end else if (xfer) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized scoreboard bench for rr_mux_arbiter against an abstract owner/pointer model.
module tb_rr_mux_arbiter;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, last, rdy, gnt;
    logic [7:0] d0, d1, d2, d3, y;
    logic [1:0] sel;
    logic       out_ready, out_valid, out_last, busy;

    rr_mux_arbiter #(.WIDTH(8), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .rdy(rdy),
        .out_ready(out_ready), .out_valid(out_valid), .y(y),
        .out_last(out_last), .gnt(gnt), .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       lst;
        logic [1:0] src;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Model: who owns the channel (-1 = nobody), where the search starts,
    // how many beats the owner has sent, and the last select value.
    int m_owner, m_ptr, m_beats, m_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_sel   = 0;
    endtask

    task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic ordy, input logic rn);
        logic [7:0] dv [4];
        logic       e_ov, e_last, e_xfer;
        logic [7:0] e_y;
        @(negedge clk);
        req = r; last = l; out_ready = ordy; rst_n = rn;
        d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        #1;
        if (!rn) model_reset();
        e_ov   = (m_owner >= 0) && r[m_owner];
        e_y    = e_ov ? dv[m_owner] : 8'h00;
        e_last = e_ov && (l[m_owner] || m_beats == MB - 1);
        e_xfer = e_ov && ordy;
        chk("gnt", 32'(gnt), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
        chk("sel", 32'(sel), 32'((m_owner >= 0) ? m_owner : m_sel));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("y", 32'(y), 32'(e_y));
        chk("out_last", 32'(out_last), 32'(e_last));
        chk("rdy", 32'(rdy), e_xfer ? 32'(1 << m_owner) : 32'd0);
        if (e_xfer) exp_q.push_back('{data: e_y, lst: e_last, src: 2'(m_owner)});
        if (rn) begin
            if (m_owner < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        m_sel   = m_owner;
                        m_beats = 0;
                    end
                end
            end else if (!r[m_owner] || (e_xfer && e_last)) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_beats = 0;
            end else if (e_xfer) begin
                m_beats++;
            end
        end
    endtask

    // Monitor: pops one expected beat for every accepted output beat.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got y=%0h expected none at %0t", y, $time);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", 32'(y), 32'(b.data));
                    chk("beat_last", 32'(out_last), 32'(b.lst));
                    chk("beat_src", 32'(sel), 32'(b.src));
                end
            end
            if (exp_q.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_missing: got %0d beats pending expected 0 at %0t", exp_q.size(), $time);
                exp_q.delete();
            end
        end
    end

    initial begin
        logic [3:0] r, l;
        req = '0; last = '0; out_ready = 1'b0; rst_n = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        model_reset();

        // Reset held with all requesting, then release.
        repeat (3) cycle(4'hF, 4'h0, 1'b1, 1'b0);
        repeat (3) cycle(4'hF, 4'h0, 1'b1, 1'b1);

        // Single-beat bursts: round-robin order.
        cycle(4'h0, 4'h0, 1'b1, 1'b0);
        repeat (10) cycle(4'hF, 4'hF, 1'b1, 1'b1);

        // Three-beat burst on requester 2, then next search starts at 3.
        cycle(4'h0, 4'h0, 1'b1, 1'b0);
        cycle(4'h4, 4'h0, 1'b1, 1'b1);
        cycle(4'h4, 4'h0, 1'b1, 1'b1);
        cycle(4'h4, 4'h0, 1'b1, 1'b1);
        cycle(4'h4, 4'h4, 1'b1, 1'b1);
        repeat (3) cycle(4'hF, 4'h0, 1'b1, 1'b1);

        // Forced release at MAX_BURST for requester 1.
        cycle(4'h0, 4'h0, 1'b1, 1'b0);
        repeat (12) cycle(4'h2, 4'h0, 1'b1, 1'b1);
        repeat (4) cycle(4'h3, 4'h0, 1'b1, 1'b1);

        // Stall then abort on requester 0.
        cycle(4'h0, 4'h0, 1'b1, 1'b0);
        repeat (6) cycle(4'h1, 4'h0, 1'b0, 1'b1);
        cycle(4'h0, 4'h0, 1'b1, 1'b1);
        repeat (3) cycle(4'h3, 4'h1, 1'b1, 1'b1);

        // Reset mid-burst.
        repeat (4) cycle(4'h4, 4'h0, 1'b1, 1'b1);
        cycle(4'h4, 4'h0, 1'b1, 1'b0);
        repeat (3) cycle(4'hF, 4'h0, 1'b1, 1'b1);

        // Random traffic with occasional resets.
        r = 4'hF;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
                l[i] = ($urandom_range(0, 3) == 0);
            end
            cycle(r, l, $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
        end
        cycle(4'h0, 4'h0, 1'b1, 1'b1);
        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
